note_sequencer: RTL and testbench



---
 rtl/note_sequencer.sv | 162 ++++++++++++++++
 tb/tb_note_sequencer.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/note_sequencer.sv
// note_sequencer: tune-playback sequencer.
// Accepts note commands over valid/ready and drives the frequency table
// address/key select. It captures the returned half-period entry and
// generates a square wave on audio_out for (note_len+1) beats.
// Optional feature macro: NOTE_GAP_EN adds a silent GAP state of one beat
// after every note.
// Ports:
//   clk, rst_n              clock, async active-low reset
//   note_valid/note_ready   command handshake
//   note_code[3:0], note_hi table index / key select of the command
//   note_len[3:0]           duration minus one, in beats
//   beat_tick               one-cycle beat strobe
//   stop                    synchronous abort
//   db_addr[3:0], db_hi     registered frequency-table inputs
//   db_entry[7:0]           half-period entry from the table (0 = silence)
//   audio_out               square-wave tone
//   busy                    high whenever not idle
module note_sequencer #(
  parameter int unsigned PRESCALE = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       note_valid,
  output logic       note_ready,
  input  logic [3:0] note_code,
  input  logic       note_hi,
  input  logic [3:0] note_len,
  input  logic       beat_tick,
  input  logic       stop,
  output logic [3:0] db_addr,
  output logic       db_hi,
  input  logic [7:0] db_entry,
  output logic       audio_out,
  output logic       busy
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] PRE_MAX = CNT_W'(PRESCALE - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_PLAY = 2'd2
`ifdef NOTE_GAP_EN
    , S_GAP = 2'd3
`endif
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       addr_d, len_q, len_d, beat_q, beat_d;
  logic             hi_d, audio_d;
  logic [CNT_W-1:0] period_q, period_d, pre_q, pre_d, half_q, half_d;

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      db_addr    <= 4'd0;
      db_hi      <= 1'b0;
      len_q      <= 4'd0;
      beat_q     <= 4'd0;
      period_q   <= '0;
      pre_q      <= '0;
      half_q     <= '0;
      audio_out  <= 1'b0;
      note_ready <= 1'b1;
      busy       <= 1'b0;
    end else begin
      state_q    <= state_d;
      db_addr    <= addr_d;
      db_hi      <= hi_d;
      len_q      <= len_d;
      beat_q     <= beat_d;
      period_q   <= period_d;
      pre_q      <= pre_d;
      half_q     <= half_d;
      audio_out  <= audio_d;
      note_ready <= (state_d == S_IDLE);
      busy       <= (state_d != S_IDLE);
    end
  end

  // Next-state and datapath
  always_comb begin
    state_d  = state_q;
    addr_d   = db_addr;
    hi_d     = db_hi;
    len_d    = len_q;
    beat_d   = beat_q;
    period_d = period_q;
    pre_d    = pre_q;
    half_d   = half_q;
    audio_d  = audio_out;

    case (state_q)
      S_IDLE: begin
        audio_d = 1'b0;
        if (note_valid && note_ready && !stop) begin
          addr_d  = note_code;
          hi_d    = note_hi;
          len_d   = note_len;
          state_d = S_LOAD;
        end
      end

      S_LOAD: begin
        audio_d = 1'b0;
        if (stop) begin
          state_d = S_IDLE;
        end else begin
          period_d = db_entry;
          beat_d   = 4'd0;
          pre_d    = '0;
          half_d   = '0;
          state_d  = S_PLAY;
        end
      end

      S_PLAY: begin
        if (stop) begin
          state_d = S_IDLE;
          audio_d = 1'b0;
        end else if (beat_tick && (beat_q == len_q)) begin
`ifdef NOTE_GAP_EN
          state_d = S_GAP;
`else
          state_d = S_IDLE;
`endif
          audio_d = 1'b0;
        end else begin
          if (beat_tick) beat_d = beat_q + 4'd1;
          // One step per PRESCALE cycles; toggle after period+1 steps
          if (pre_q == PRE_MAX) begin
            pre_d = '0;
            if (half_q == period_q) begin
              half_d = '0;
              // A zero entry is a rest: keep the pin low
              if (period_q != '0) audio_d = ~audio_out;
            end else begin
              half_d = half_q + CNT_W'(1);
            end
          end else begin
            pre_d = pre_q + CNT_W'(1);
          end
        end
      end

`ifdef NOTE_GAP_EN
      S_GAP: begin
        audio_d = 1'b0;
        if (stop || beat_tick) state_d = S_IDLE;
      end
`endif

      default: begin
        state_d = S_IDLE;
        audio_d = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_note_sequencer.sv
// Directed self-checking bench for note_sequencer (PRESCALE = 4).
// A small frequency table model drives db_entry from db_addr/db_hi.
module tb_note_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       note_valid, note_hi, beat_tick, stop;
  logic [3:0] note_code, note_len;
  logic       note_ready, db_hi, audio_out, busy;
  logic [3:0] db_addr;
  logic [7:0] db_entry;

  int tests = 0;
  int fails = 0;

  note_sequencer #(.PRESCALE(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .note_valid (note_valid),
    .note_ready (note_ready),
    .note_code  (note_code),
    .note_hi    (note_hi),
    .note_len   (note_len),
    .beat_tick  (beat_tick),
    .stop       (stop),
    .db_addr    (db_addr),
    .db_hi      (db_hi),
    .db_entry   (db_entry),
    .audio_out  (audio_out),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Frequency table model: code 0 -> 0x33/0x30, codes >= 13 are rests
  always_comb begin
    if (db_addr >= 4'd13)      db_entry = 8'd0;
    else if (db_addr == 4'd0)  db_entry = db_hi ? 8'h30 : 8'h33;
    else                       db_entry = 8'(20) + 8'(db_addr);
  end

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic pulse_tick();
    beat_tick = 1'b1;
    @(negedge clk);
    beat_tick = 1'b0;
  endtask

  // Count negedges until audio_out reaches lvl (bounded by limit)
  task automatic wait_audio(input logic lvl, input int limit, output int cnt);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (audio_out !== lvl && cnt < limit);
  endtask

  // Present a command for one cycle; returns at the negedge in LOAD
  task automatic send_note(input logic [3:0] code, input logic hi, input logic [3:0] len);
    note_valid = 1'b1; note_code = code; note_hi = hi; note_len = len;
    @(negedge clk);
    note_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cycles(2);
    rst_n = 1'b1;
    cycles(1);
    tests++;
    if ({note_ready, busy, audio_out, db_addr, db_hi} !== 8'b1_0_0_0000_0) begin
      fails++;
      $display("FAIL reset: ready/busy/audio/addr/hi = %b, expected 10000000",
               {note_ready, busy, audio_out, db_addr, db_hi});
    end
  endtask

  task automatic test_tone_lo();
    int cnt;
    send_note(4'd0, 1'b0, 4'd1);
    tests++;
    if (note_ready !== 1'b0 || busy !== 1'b1 || db_addr !== 4'd0 || db_hi !== 1'b0) begin
      fails++;
      $display("FAIL load_lo: ready=%b busy=%b addr=%0d hi=%b, expected 0 1 0 0",
               note_ready, busy, db_addr, db_hi);
    end
    wait_audio(1'b1, 400, cnt);
    tests++;
    if (cnt != 209) begin fails++; $display("FAIL first_rise_lo: %0d cycles, expected 209", cnt); end
    wait_audio(1'b0, 400, cnt);
    tests++;
    if (cnt != 208) begin fails++; $display("FAIL half_lo_fall: %0d cycles, expected 208", cnt); end
    wait_audio(1'b1, 400, cnt);
    tests++;
    if (cnt != 208) begin fails++; $display("FAIL half_lo_rise: %0d cycles, expected 208", cnt); end
    pulse_tick();
    tests++;
    if (busy !== 1'b1 || audio_out !== 1'b1) begin
      fails++;
      $display("FAIL tick1_lo: busy=%b audio=%b, expected 1 1", busy, audio_out);
    end
    pulse_tick();
`ifdef NOTE_GAP_EN
    tests++;
    if (busy !== 1'b1 || note_ready !== 1'b0 || audio_out !== 1'b0) begin
      fails++;
      $display("FAIL gap_lo: busy=%b ready=%b audio=%b, expected 1 0 0", busy, note_ready, audio_out);
    end
    pulse_tick();
`endif
    tests++;
    if (busy !== 1'b0 || note_ready !== 1'b1 || audio_out !== 1'b0) begin
      fails++;
      $display("FAIL end_lo: busy=%b ready=%b audio=%b, expected 0 1 0", busy, note_ready, audio_out);
    end
  endtask

  task automatic test_tone_hi();
    int cnt;
    send_note(4'd0, 1'b1, 4'd0);
    tests++;
    if (db_hi !== 1'b1 || db_addr !== 4'd0) begin
      fails++; $display("FAIL load_hi: addr=%0d hi=%b, expected 0 1", db_addr, db_hi);
    end
    wait_audio(1'b1, 400, cnt);
    tests++;
    if (cnt != 197) begin fails++; $display("FAIL first_rise_hi: %0d cycles, expected 197", cnt); end
    wait_audio(1'b0, 400, cnt);
    tests++;
    if (cnt != 196) begin fails++; $display("FAIL half_hi: %0d cycles, expected 196", cnt); end
    pulse_tick();
`ifdef NOTE_GAP_EN
    pulse_tick();
`endif
    tests++;
    if (busy !== 1'b0 || note_ready !== 1'b1) begin
      fails++; $display("FAIL end_hi: busy=%b ready=%b, expected 0 1", busy, note_ready);
    end
  endtask

  task automatic test_rest();
    int bad;
    bad = 0;
    send_note(4'd13, 1'b0, 4'd2);
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < 60; i++) begin
        @(negedge clk);
        if (audio_out !== 1'b0 || busy !== 1'b1) bad++;
      end
      pulse_tick();
    end
    tests++;
    if (bad != 0) begin fails++; $display("FAIL rest_quiet: %0d bad cycles, expected 0", bad); end
    tests++;
    if (busy !== 1'b1 || audio_out !== 1'b0) begin
      fails++; $display("FAIL rest_two_beats: busy=%b audio=%b, expected 1 0", busy, audio_out);
    end
    pulse_tick();
`ifdef NOTE_GAP_EN
    pulse_tick();
`endif
    tests++;
    if (busy !== 1'b0 || note_ready !== 1'b1) begin
      fails++; $display("FAIL rest_end: busy=%b ready=%b, expected 0 1", busy, note_ready);
    end
  endtask

  task automatic test_stop();
    // code 2 -> entry 22 -> half-period 92; high from 93 to 184 cycles
    send_note(4'd2, 1'b1, 4'd3);
    cycles(120);
    tests++;
    if (audio_out !== 1'b1) begin fails++; $display("FAIL stop_pre: audio=%b, expected 1", audio_out); end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    tests++;
    if ({busy, note_ready, audio_out, db_addr, db_hi} !== 8'b0_1_0_0010_1) begin
      fails++;
      $display("FAIL stop_play: busy/ready/audio/addr/hi = %b, expected 01000101",
               {busy, note_ready, audio_out, db_addr, db_hi});
    end
    // Command together with stop in IDLE is refused
    note_valid = 1'b1; stop = 1'b1; note_code = 4'd4;
    @(negedge clk);
    note_valid = 1'b0; stop = 1'b0;
    cycles(1);
    tests++;
    if (busy !== 1'b0 || note_ready !== 1'b1 || db_addr !== 4'd2) begin
      fails++; $display("FAIL stop_idle: busy=%b ready=%b addr=%0d, expected 0 1 2", busy, note_ready, db_addr);
    end
    // stop and the final tick together: stop wins, straight to IDLE
    send_note(4'd0, 1'b0, 4'd0);
    cycles(5);
    stop = 1'b1; beat_tick = 1'b1;
    @(negedge clk);
    stop = 1'b0; beat_tick = 1'b0;
    tests++;
    if (busy !== 1'b0 || note_ready !== 1'b1 || audio_out !== 1'b0) begin
      fails++; $display("FAIL stop_tick: busy=%b ready=%b audio=%b, expected 0 1 0", busy, note_ready, audio_out);
    end
  endtask

  task automatic test_len0();
    send_note(4'd1, 1'b0, 4'd0);
    cycles(10);
    pulse_tick();
`ifdef NOTE_GAP_EN
    cycles(5);
    tests++;
    if (busy !== 1'b1 || audio_out !== 1'b0 || note_ready !== 1'b0) begin
      fails++; $display("FAIL gap_len0: busy=%b audio=%b ready=%b, expected 1 0 0", busy, audio_out, note_ready);
    end
    pulse_tick();
`endif
    tests++;
    if (busy !== 1'b0 || note_ready !== 1'b1) begin
      fails++; $display("FAIL end_len0: busy=%b ready=%b, expected 0 1", busy, note_ready);
    end
  endtask

  task automatic test_back_to_back();
    // Valid held through LOAD/PLAY with a changed code must not re-accept
    note_valid = 1'b1; note_code = 4'd3; note_hi = 1'b0; note_len = 4'd5;
    @(negedge clk);
    note_code = 4'd5; note_hi = 1'b1;
    cycles(6);
    tests++;
    if (db_addr !== 4'd3 || db_hi !== 1'b0 || note_ready !== 1'b0) begin
      fails++; $display("FAIL no_reaccept: addr=%0d hi=%b ready=%b, expected 3 0 0", db_addr, db_hi, note_ready);
    end
    note_valid = 1'b0;
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  task automatic test_async_reset();
    int cnt;
    send_note(4'd0, 1'b1, 4'd3);
    wait_audio(1'b1, 400, cnt);
    tests++;
    if (audio_out !== 1'b1) begin fails++; $display("FAIL arst_pre: audio=%b, expected 1", audio_out); end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if ({note_ready, busy, audio_out, db_addr, db_hi} !== 8'b1_0_0_0000_0) begin
      fails++;
      $display("FAIL arst: ready/busy/audio/addr/hi = %b, expected 10000000",
               {note_ready, busy, audio_out, db_addr, db_hi});
    end
    @(negedge clk);
    rst_n = 1'b1;
    cycles(2);
    tests++;
    if (busy !== 1'b0 || note_ready !== 1'b1 || audio_out !== 1'b0) begin
      fails++; $display("FAIL arst_after: busy=%b ready=%b audio=%b, expected 0 1 0", busy, note_ready, audio_out);
    end
  endtask

  initial begin
    rst_n = 1'b0; note_valid = 1'b0; note_code = 4'd0; note_hi = 1'b0;
    note_len = 4'd0; beat_tick = 1'b0; stop = 1'b0;
    @(negedge clk);
    test_reset();
    test_tone_lo();
    test_tone_hi();
    test_rest();
    test_stop();
    test_len0();
    test_back_to_back();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
